// File: rtl/imem_line_loader.sv
// imem_line_loader: streams 48-bit instruction words in over valid/ready,
// packs LANES words per memory line and issues one single-cycle write per line
// on the instruction memory write port (iMem_WEPin / WEAddress / idataWrite).
//
// Ports:
//   clock, reset        - clock; synchronous active-high reset
//   start, base_addr    - begin a load at line address base_addr (IDLE only)
//   in_valid/in_ready   - word handshake; in_ready decoded from state only
//   in_data, in_last    - instruction word and end-of-program marker
//   iMem_WEPin          - one-cycle write enable per line
//   WEAddress           - line address of the write
//   idataWrite          - packed line, lane k at [DATA_W*k +: DATA_W]
//   busy, done          - load in progress / one-cycle completion pulse
//   wrapped             - sticky: address wrapped past all-ones this load
//   lines_written       - lines written this load
//   checksum            - XOR of accepted words
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.
module imem_line_loader #(
   parameter int unsigned       DATA_W   = 48,
   parameter int unsigned       LANES    = 5,
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [DATA_W-1:0] PAD_WORD = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_last,
   output logic                      iMem_WEPin,
   output logic [ADDR_W-1:0]         WEAddress,
   output logic [DATA_W*LANES-1:0]   idataWrite,
   output logic                      busy,
   output logic                      done,
   output logic                      wrapped,
   output logic [ADDR_W:0]           lines_written,
   output logic [DATA_W-1:0]         checksum
);

   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned LINE_W = DATA_W * LANES;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [LANE_W-1:0]   r_lane_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_line;
   logic [LINE_W-1:0]   w_line_nxt;
   logic                r_eol;
   logic                r_we;
   logic [ADDR_W-1:0]   r_waddr;
   logic [LINE_W-1:0]   r_wdata;
   logic                r_busy;
   logic                r_done;
   logic                r_wrapped;
   logic [CNT_W-1:0]    r_lines;
   logic                w_accept;

   assign in_ready = (r_state == S_COLLECT);
   assign w_accept = in_ready && in_valid;

   // Next state plus the line as it would look with the current word merged in
   always_comb begin
      w_state_nxt = r_state;
      w_line_nxt  = r_line;
      for (int k = 0; k < LANES; k++) begin
         if (LANE_W'(k) == r_lane_cnt) begin
            w_line_nxt[k*DATA_W +: DATA_W] = in_data;
         end else if (in_last && (LANE_W'(k) > r_lane_cnt)) begin
            w_line_nxt[k*DATA_W +: DATA_W] = PAD_WORD;
         end
      end
      case (r_state)
         S_IDLE:    if (start) w_state_nxt = S_COLLECT;
         S_COLLECT: if (w_accept && (in_last || (r_lane_cnt == LANE_W'(LANES-1))))
                       w_state_nxt = S_WRITE;
         S_WRITE:   w_state_nxt = r_eol ? S_DONE : S_COLLECT;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Datapath and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_lane_cnt <= '0;
         r_addr     <= '0;
         r_line     <= '0;
         r_eol      <= 1'b0;
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wrapped  <= 1'b0;
         r_lines    <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr     <= base_addr;
                  r_lane_cnt <= '0;
                  r_lines    <= '0;
                  r_wrapped  <= 1'b0;
                  r_eol      <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_COLLECT: begin
               if (w_accept) begin
                  r_line     <= w_line_nxt;
                  r_lane_cnt <= r_lane_cnt + LANE_W'(1);
                  if (in_last) r_eol <= 1'b1;
                  // Launch the write with the just-completed line
                  if (w_state_nxt == S_WRITE) begin
                     r_we    <= 1'b1;
                     r_waddr <= r_addr;
                     r_wdata <= w_line_nxt;
                  end
               end
            end
            S_WRITE: begin
               r_addr     <= r_addr + ADDR_W'(1);
               r_lines    <= r_lines + CNT_W'(1);
               r_lane_cnt <= '0;
               if (&r_addr) r_wrapped <= 1'b1;
               if (r_eol) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   // XOR of accepted words only; pad lanes never pass through here
   always_ff @(posedge clock) begin
      if (reset)                               r_checksum <= '0;
      else if ((r_state == S_IDLE) && start)   r_checksum <= '0;
      else if (w_accept)                       r_checksum <= r_checksum ^ in_data;
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

   assign iMem_WEPin    = r_we;
   assign WEAddress     = r_waddr;
   assign idataWrite    = r_wdata;
   assign busy          = r_busy;
   assign done          = r_done;
   assign wrapped       = r_wrapped;
   assign lines_written = r_lines;

endmodule

// File: tb/tb_imem_line_loader.sv
// Bench for imem_line_loader: directed loads with a write scoreboard.
module tb_imem_line_loader;

   localparam logic [47:0] PAD = 48'hFFFF_FFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_last;
   logic [7:0]    base_addr;
   logic [47:0]   in_data;
   logic          in_ready, iMem_WEPin, busy, done, wrapped;
   logic [7:0]    WEAddress;
   logic [239:0]  idataWrite;
   logic [8:0]    lines_written;
   logic [47:0]   checksum;

   int n_tests = 0;
   int n_fail  = 0;
   logic [247:0] sb[$];     // {addr, line}
   logic [47:0]  wq[$];     // words of the next load

   imem_line_loader #(.DATA_W(48), .LANES(5), .ADDR_W(8), .PAD_WORD(PAD)) dut (
      .clock(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .iMem_WEPin(iMem_WEPin), .WEAddress(WEAddress), .idataWrite(idataWrite),
      .busy(busy), .done(done), .wrapped(wrapped), .lines_written(lines_written),
      .checksum(checksum)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (reset === 1'b0 && iMem_WEPin === 1'b1) begin
         check("in_ready_in_write", 256'(in_ready), 256'(0));
         if (sb.size() == 0) begin
            check("unexpected_write", 256'(iMem_WEPin), 256'(0));
         end else begin
            logic [247:0] e;
            e = sb.pop_front();
            check("wr_addr", 256'(WEAddress), 256'(e[247:240]));
            check("wr_data", 256'(idataWrite), 256'(e[239:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start(input logic [7:0] base);
      start = 1'b1; base_addr = base;
      tick();
      start = 1'b0; base_addr = 8'h5A;
      check("busy_after_start", 256'(busy), 256'(1));
      check("ready_after_start", 256'(in_ready), 256'(1));
   endtask

   task automatic send(input logic [47:0] d, input logic last, input bit gaps);
      bit acc = 1'b0;
      int guard = 0;
      if (gaps) begin
         int n = $urandom_range(2, 0);
         repeat (n) tick();
      end
      in_valid = 1'b1; in_data = d; in_last = last;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = (in_ready === 1'b1);
         tick();
         guard++;
      end
      in_valid = 1'b0; in_last = 1'b0; in_data = 48'hDEAD_BEEF_0BAD;
      check("handshake", 256'(acc), 256'(1));
   endtask

   // Full load of wq at base; builds expected lines alongside the stimulus
   task automatic load(input logic [7:0] base, input bit gaps);
      logic [239:0] line = {5{PAD}};
      logic [47:0]  cks = '0;
      logic [7:0]   a = base;
      int           lane = 0, nl = 0;
      bit           wr = 1'b0;
      pulse_start(base);
      check("lines_cleared", 256'(lines_written), 256'(0));
      check("wrapped_cleared", 256'(wrapped), 256'(0));
      for (int i = 0; i < wq.size(); i++) begin
         bit last = (i == wq.size() - 1);
         line[lane*48 +: 48] = wq[i];
         cks ^= wq[i];
         if (lane == 4 || last) begin
            sb.push_back({a, line});
            nl++;
            if (a == 8'hFF) wr = 1'b1;
            a++;
            lane = 0;
            line = {5{PAD}};
         end else begin
            lane++;
         end
         send(wq[i], last, gaps);
      end
      check("we_after_last", 256'(iMem_WEPin), 256'(1));
      tick();
      check("done_pulse", 256'(done), 256'(1));
      check("busy_in_done", 256'(busy), 256'(0));
      check("we_single_cycle", 256'(iMem_WEPin), 256'(0));
      check("lines_written", 256'(lines_written), 256'(nl));
      check("wrapped", 256'(wrapped), 256'(wr));
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("checksum", 256'(checksum), 256'(cks));
`else
      check("checksum", 256'(checksum), 256'(0));
`endif
      tick();
      check("done_cleared", 256'(done), 256'(0));
      check("idle_not_ready", 256'(in_ready), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0;
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      tick(); tick();
      check("rst_in_ready", 256'(in_ready), 256'(0));
      check("rst_we", 256'(iMem_WEPin), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_addr", 256'(WEAddress), 256'(0));
      check("rst_data", 256'(idataWrite), 256'(0));
      check("rst_lines", 256'(lines_written), 256'(0));
      reset = 1'b0;
      tick();

      // Basic single full line
      wq = '{48'h1, 48'h2, 48'h3, 48'h4, 48'h5};
      load(8'h10, 1'b0);
      check("basic_addr_hold", 256'(WEAddress), 256'(8'h10));
      check("basic_data_hold", 256'(idataWrite),
            256'({48'h5, 48'h4, 48'h3, 48'h2, 48'h1}));

      // Short final line padded, gap-free then with gaps
      wq = '{48'h1111, 48'h2222, 48'h3333, 48'h4444, 48'h5555, 48'h6666, 48'h7777};
      load(8'h30, 1'b0);
      load(8'h30, 1'b1);
      load(8'h31, 1'b1);

      // Address wrap
      wq.delete();
      for (int i = 0; i < 10; i++) wq.push_back(48'hA000_0000_0000 | 48'(i * 3 + 1));
      load(8'hFF, 1'b0);
      wq = '{48'h42};
      load(8'h00, 1'b0);

      // Reset mid-line discards partial data
      pulse_start(8'h40);
      send(48'hBAD1, 1'b0, 1'b0);
      send(48'hBAD2, 1'b0, 1'b0);
      send(48'hBAD3, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_ready", 256'(in_ready), 256'(0));
      check("mid_rst_busy", 256'(busy), 256'(0));
      check("mid_rst_addr", 256'(WEAddress), 256'(0));
      check("mid_rst_data", 256'(idataWrite), 256'(0));
      check("mid_rst_lines", 256'(lines_written), 256'(0));
      check("mid_rst_chk", 256'(checksum), 256'(0));
      repeat (3) tick();
      wq = '{48'hC1, 48'hC2, 48'hC3, 48'hC4, 48'hC5};
      load(8'h20, 1'b0);

      // Checksum cancels to zero
      wq = '{48'hA, 48'h5, 48'hF};
      load(8'h50, 1'b0);

      repeat (3) tick();
      check("sb_drained", 256'(sb.size()), 256'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_line_loader.md
# imem_line_loader

Streaming writer for the instruction memory write port of `top_with_mem`. It accepts 48-bit instruction words over a valid/ready stream, packs five words into one 240-bit line, and drives `iMem_WEPin` / `WEAddress` / `idataWrite` with one single-cycle write per line. This replaces hand-driven testbench writes and `$readmemh` preloading for run-time program loading.

## Interface
- `DATA_W`, 48, width of one instruction word (one read lane).
- `LANES`, 5, words per memory line.
- `ADDR_W`, 8, memory line address width.
- `PAD_WORD`, 48'h0, fill value for unused lanes of a short final line.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first line address; captured on an accepted `start`.
- `in_valid`  in  1  word on `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  DATA_W  instruction word.
- `in_last`  in  1  accepted word is the final word of the program.
- `iMem_WEPin`  out  1  memory write enable, one cycle per line.
- `WEAddress`  out  ADDR_W  line address for the write.
- `idataWrite`  out  DATA_W*LANES  packed line; lane k occupies bits [48k+47:48k].
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  one-cycle pulse after the final line write.
- `wrapped`  out  1  sticky; address wrapped from 2^ADDR_W-1 to 0 during this load.
- `lines_written`  out  ADDR_W+1  count of lines written during this load.
- `checksum`  out  DATA_W  XOR of all accepted words; see Configuration.

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE to COLLECT when `start` is high. Capture `base_addr` into the address register. Clear the lane counter, `lines_written`, `wrapped`, and `checksum`. `start` in any other state is ignored.
- COLLECT:
  - `in_ready` = 1. A word is accepted when `in_valid && in_ready`.
  - The accepted word is stored in lane `lane_cnt`, and `lane_cnt` increments.
  - On acceptance with `lane_cnt == LANES-1`, or with `in_last` = 1, go to WRITE.
  - On `in_last`, lanes above the current lane are filled with `PAD_WORD`, and the end-of-load flag is set.
- WRITE:
  - Exactly one cycle. `iMem_WEPin` = 1, `WEAddress` = current address, `idataWrite` = assembled line. `in_ready` = 0.
  - Next cycle: address increments modulo 2^ADDR_W. If the old address was all-ones, `wrapped` is set. `lines_written` increments and `lane_cnt` clears.
  - Then DONE if the end-of-load flag is set, else COLLECT.
- DONE: `done` = 1 for one cycle, `busy` = 0, then IDLE. `lines_written`, `wrapped`, and `checksum` hold until the next `start`.
- Outside WRITE, `iMem_WEPin` = 0 and `WEAddress` / `idataWrite` hold their last written values.
- Reset mid-load: every output returns to its reset value, any partial line is discarded, the FSM goes to IDLE, and no write is issued.

## Timing
- Reset values: `in_ready`, `iMem_WEPin`, `busy`, `done`, `wrapped` = 0; `WEAddress`, `idataWrite`, `lines_written`, `checksum` = 0.
- `start` accepted in cycle t: `busy` and `in_ready` are high in cycle t+1.
- Final lane accepted in cycle t: `iMem_WEPin` is high in cycle t+1 only, and `in_ready` returns to 1 in cycle t+2.
- Full-rate streaming sustains 5 words per 6 cycles.
- `in_last` accepted in cycle t: write in cycle t+1, `done` in cycle t+2, IDLE in cycle t+3.
- `in_valid` may drop at any time. `in_data` and `in_last` are sampled only on acceptance.
- All outputs are registered. There is no combinational path from inputs to outputs except `in_ready`, which is decoded from state only.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates the XOR of every accepted `in_data`. Pad words are excluded.
  - It is cleared on an accepted `start`.
- Undefined: the checksum logic is not compiled and `checksum` is tied to 0.

## Test plan
- Basic load: `base_addr`=8'h10, stream 5 words 48'h1..48'h5 with `in_last` on word 5 -> one write with `WEAddress`=8'h10 and `idataWrite`={48'h5,48'h4,48'h3,48'h2,48'h1}. `done` fires 1 cycle after the write, and `lines_written`=1.
- Short final line: stream 7 words with `PAD_WORD`=48'hFFFF_FFFF_FFFF and `in_last` on word 7.
  - Two writes, at `base_addr` and `base_addr`+1.
  - The second line is lanes 0–1 = words 6–7 and lanes 2–4 = PAD. `lines_written`=2.
- Wrap-around: `base_addr`=8'hFF, 10 words -> writes at 8'hFF then 8'h00, and `wrapped`=1 after the load.
- Backpressure and gaps: toggle `in_valid` randomly -> the write contents are identical to the gap-free run, and `in_ready`=0 during every WRITE cycle.
- Reset mid-load: assert `reset` after word 3 of a line -> no write is issued, all outputs are 0, and a new `start` loads correctly from lane 0.
- Checksum (macro defined): words 48'hA, 48'h5, 48'hF with `in_last` -> `checksum`=48'h0. With the macro undefined, `checksum`=0 throughout.
